// File: rtl/relu_maxpool_quant.sv
// Post-convolution stage: POOL_SIZE x POOL_SIZE max-pool, ReLU and saturating
// requantisation of a signed accumulator map. One output pixel is written per clock.
module relu_maxpool_quant #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_WIDTH  = 26,
  parameter int MAP_SIZE   = 32,
  parameter int POOL_SIZE  = 2,
  parameter int SHIFT      = 8
) (
  input  logic                                                            clk,
  input  logic                                                            rst_n,
  input  logic                                                            start,
  input  logic [BUF_WIDTH*MAP_SIZE*MAP_SIZE-1:0]                          ifm,
  output logic [DATA_WIDTH*(MAP_SIZE/POOL_SIZE)*(MAP_SIZE/POOL_SIZE)-1:0] ofm,
  output logic                                                            idle,
  output logic                                                            finish
);

  // state  | meaning
  // S_IDLE | waiting for start; idle=1
  // S_RUN  | writing one output pixel per clock, row-major
  // S_DONE | one-cycle finish pulse, then back to S_IDLE

  localparam int OUT_SIZE = MAP_SIZE / POOL_SIZE;
  localparam int CNT_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int WIN      = POOL_SIZE * POOL_SIZE;
  localparam logic signed [BUF_WIDTH-1:0] SAT_MAX = BUF_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [DATA_WIDTH*OUT_SIZE*OUT_SIZE-1:0] r_ofm;

  logic                        w_last_col;
  logic                        w_last_px;
  logic signed [BUF_WIDTH-1:0] w_win [WIN];
  logic signed [BUF_WIDTH-1:0] w_max;
  logic signed [BUF_WIDTH-1:0] w_relu;
  logic signed [BUF_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0]       w_px;
  int                          w_out_idx;

  assign w_last_col = (r_col == CNT_W'(OUT_SIZE - 1));
  assign w_last_px  = w_last_col && (r_row == CNT_W'(OUT_SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_px) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle   = 1'b0;
    finish = 1'b0;
    case (r_state)
      S_IDLE:  idle   = 1'b1;
      S_DONE:  finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_row <= '0;
        r_col <= '0;
      end
    end else if (r_state == S_RUN) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  // Window taps are read straight from the held ifm bus; nothing is buffered.
  always_comb begin
    w_win = '{default: '0};
    for (int a = 0; a < POOL_SIZE; a++) begin
      for (int b = 0; b < POOL_SIZE; b++) begin
        w_win[a*POOL_SIZE+b] =
          ifm[(MAP_SIZE*(POOL_SIZE*int'(r_row)+a) + POOL_SIZE*int'(r_col) + b)*BUF_WIDTH +: BUF_WIDTH];
      end
    end
  end

  always_comb begin
    w_max = w_win[0];
    for (int k = 1; k < WIN; k++) begin
      if (w_win[k] > w_max) w_max = w_win[k];
    end
  end

  assign w_relu = w_max[BUF_WIDTH-1] ? '0 : w_max;
  assign w_q    = w_relu >>> SHIFT;
  assign w_px   = (w_q > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] : w_q[DATA_WIDTH-1:0];

  assign w_out_idx = OUT_SIZE * int'(r_row) + int'(r_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ofm <= '0;
    end else if (r_state == S_RUN) begin
      r_ofm[w_out_idx*DATA_WIDTH +: DATA_WIDTH] <= w_px;
    end
  end

  assign ofm = r_ofm;

endmodule

// File: tb/tb_relu_maxpool_quant.sv
// Scoreboard bench for relu_maxpool_quant: expected maps are queued at start and
// compared by a monitor on every finish pulse.
module tb_relu_maxpool_quant;

  localparam int DW = 8;
  localparam int BW = 26;
  localparam int MS = 32;
  localparam int OS = 16;
  localparam int OW = DW * OS * OS;

  typedef logic [OW-1:0] omap_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [BW*MS*MS-1:0] ifm;
  logic [OW-1:0]       ofm;
  logic                idle;
  logic                finish;

  int    checks;
  int    errors;
  int    in_map [MS][MS];
  omap_t sb_q [$];

  relu_maxpool_quant dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ifm    (ifm),
    .ofm    (ofm),
    .idle   (idle),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: max over the 2x2 window, clamp negatives, divide by 256, clip at 127.
  function automatic int ref_px(input int r, input int c);
    int m;
    m = in_map[2*r][2*c];
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        if (in_map[2*r+a][2*c+b] > m) m = in_map[2*r+a][2*c+b];
    if (m < 0) m = 0;
    m = m / 256;
    if (m > 127) m = 127;
    return m;
  endfunction

  task automatic load_and_expect();
    omap_t e;
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++)
        ifm[(MS*i+j)*BW +: BW] = BW'(in_map[i][j]);
    e = '0;
    for (int r = 0; r < OS; r++)
      for (int c = 0; c < OS; c++)
        e[(OS*r+c)*DW +: DW] = DW'(ref_px(r, c));
    sb_q.push_back(e);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++)
        in_map[i][j] = v;
  endtask

  task automatic fill_rand();
    logic [31:0] raw;
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++) begin
        raw = $urandom;
        case ($urandom_range(0, 3))
          0: in_map[i][j] = int'({{6{raw[25]}}, raw[25:0]});
          1: in_map[i][j] = int'($urandom_range(0, 70000)) - 35000;
          2: in_map[i][j] = int'($urandom_range(0, 40000));
          default: in_map[i][j] = -int'($urandom_range(0, 1000));
        endcase
      end
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!idle && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("run_timeout_idle", 32'(idle), 32'd1);
  endtask

  task automatic run_map();
    load_and_expect();
    start_pulse();
    wait_idle();
  endtask

  function automatic int px(input int r, input int c);
    return int'(ofm[(OS*r+c)*DW +: DW]);
  endfunction

  // Monitor: every finish pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (finish) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish actual=1 required=0");
      end else begin
        omap_t e;
        int    shown;
        e = sb_q.pop_front();
        shown = 0;
        for (int k = 0; k < OS*OS; k++) begin
          checks++;
          if (ofm[k*DW +: DW] !== e[k*DW +: DW]) begin
            errors++;
            if (shown < 8) begin
              $display("FAIL ofm_px r=%0d c=%0d actual=%0d required=%0d",
                       k / OS, k % OS, ofm[k*DW +: DW], e[k*DW +: DW]);
              shown++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    ifm    = '0;
    repeat (3) @(negedge clk);
    chk("reset_ofm_zero", 32'(ofm == '0), 32'd1);
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_finish", 32'(finish), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // all negative -> zeros
    fill_const(-5);
    run_map();
    chk("neg_px_0_0", 32'(px(0, 0)), 32'd0);

    // diagonal ramp
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++)
        in_map[i][j] = (i + j) << 8;
    run_map();
    chk("ramp_px_0_0", 32'(px(0, 0)), 32'd2);
    chk("ramp_px_15_15", 32'(px(15, 15)), 32'd62);
    chk("ramp_px_3_7", 32'(px(3, 7)), 32'd22);

    // saturation and shift boundaries
    fill_const(-5);
    in_map[0][0] = 33554431;
    in_map[1][3] = 32767;
    in_map[0][4] = 32768;
    in_map[1][7] = 255;
    in_map[0][8] = 256;
    run_map();
    chk("sat_max_pos", 32'(px(0, 0)), 32'd127);
    chk("sat_32767", 32'(px(0, 1)), 32'd127);
    chk("sat_32768", 32'(px(0, 2)), 32'd127);
    chk("shift_255", 32'(px(0, 3)), 32'd0);
    chk("shift_256", 32'(px(0, 4)), 32'd1);
    chk("bg_neg", 32'(px(0, 5)), 32'd0);

    // handshake timing with an ignored second start at E50
    fill_rand();
    load_and_expect();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("hs_idle_after_e0", 32'(idle), 32'd0);
    for (int k = 1; k <= 257; k++) begin
      @(posedge clk);
      #1;
      if (k == 49) start = 1'b1;
      if (k == 50) start = 1'b0;
      if (finish !== (k == 256)) begin
        chk($sformatf("hs_finish_e%0d", k), 32'(finish), 32'(k == 256));
      end else checks++;
      if (idle !== (k >= 257)) begin
        chk($sformatf("hs_idle_e%0d", k), 32'(idle), 32'(k >= 257));
      end else checks++;
    end
    repeat (300) @(negedge clk);
    chk("hs_no_restart_idle", 32'(idle), 32'd1);

    // reset mid-run
    fill_rand();
    load_and_expect();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ofm_zero", 32'(ofm == '0), 32'd1);
    chk("abort_idle", 32'(idle), 32'd1);
    chk("abort_finish", 32'(finish), 32'd0);
    sb_q.delete(sb_q.size() - 1);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_stays_idle", 32'(idle), 32'd1);
    chk("abort_ofm_still_zero", 32'(ofm == '0), 32'd1);

    fill_rand();
    run_map();

    // random chained runs
    for (int n = 0; n < 20; n++) begin
      fill_rand();
      run_map();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
